p66b_lock_ctrl: RTL and testbench
=================================

# p66b_lock_ctrl

Clause-49 style block-lock controller for the 64b/66b receive path. Sits directly after the RX gearbox. It watches the 2-bit sync header of each 66-bit block, decides block lock, and commands the gearbox alignment slip. It monitors the header error rate (hi-BER) and forwards blocks downstream only while locked.

## Interface

Parameters:
- `LOCK_CNT`, 64: consecutive valid headers required to declare lock.
- `WIN_CNT`, 64: blocks per invalid-header test window while locked.
- `BAD_LIMIT`, 16: invalid headers within one window that drop lock.
- `SLIP_WAIT`, 4: blocks ignored after a slip while the gearbox realigns.
- `BER_TIMER`, 19531: clock cycles per hi-BER window (125 µs at 156.25 MHz).
- `BER_LIMIT`, 16: invalid headers per BER window that set hi-BER.

Ports:
- `i_clk`, in, 1: clock.
- `i_reset`, in, 1: asynchronous, active-high reset.
- `S_VALID`, in, 1: one block present this cycle.
- `S_DATA`, in, 66: block; `S_DATA[1:0]` is the sync header.
- `o_slip`, out, 1: one-cycle pulse; gearbox shifts alignment by one bit.
- `o_block_lock`, out, 1: block lock achieved.
- `o_hi_ber`, out, 1: high bit-error-rate condition.
- `M_VALID`, out, 1: forwarded block strobe.
- `M_DATA`, out, 66: forwarded block.

## Operation

- Header valid: `S_DATA[1:0]` is 2'b01 or 2'b10. 2'b00 and 2'b11 are invalid. Only cycles with `S_VALID` are evaluated.
- FSM states:
  - HUNT:
    - Each valid header increments `good_cnt`.
    - An invalid header pulses `o_slip`, clears `good_cnt`, and goes to WAIT.
    - When `good_cnt` reaches `LOCK_CNT`, go to LOCKED, set `o_block_lock`=1, and clear the window counters.
  - LOCKED:
    - `win_cnt` counts blocks and `bad_cnt` counts invalid headers.
    - When `bad_cnt` reaches `BAD_LIMIT`: set `o_block_lock`=0, pulse `o_slip`, go to WAIT.
    - When `win_cnt` reaches `WIN_CNT` without that: clear both counters and stay in LOCKED.
    - If both happen on the same block, loss of lock wins.
  - WAIT: count `SLIP_WAIT` `S_VALID` blocks with headers ignored, then go to HUNT with `good_cnt`=0.
- hi-BER monitor:
  - Active only while `o_block_lock`=1. Otherwise the cycle timer, `ber_cnt` and `o_hi_ber` are held at 0.
  - The timer counts clock cycles from 0 to `BER_TIMER`-1 and wraps.
  - Each invalid header increments `ber_cnt`, saturating at `BER_LIMIT`.
  - Reaching `BER_LIMIT` sets `o_hi_ber`=1 immediately.
  - On timer wrap:
    - If `ber_cnt` is below `BER_LIMIT`, clear `o_hi_ber`.
    - Then `ber_cnt` restarts at 0.
    - An invalid header on the wrap cycle is counted in the expiring window.
- Forwarding:
  - `M_VALID` <= `S_VALID` && `o_block_lock`, using the registered lock value before this block's update.
  - `M_DATA` <= `S_DATA` on every `S_VALID`.
- Counter widths: `$clog2(param+1)`. No counter may wrap; each is bounded by its state transition.

## Timing

- Reset values: every output is 0; FSM is in HUNT; all counters are 0.
- `o_slip`, `o_block_lock`, `o_hi_ber`, `M_VALID`, `M_DATA` are all registered, one cycle after the triggering `S_VALID`.
- `o_slip` is never high on two consecutive cycles. At most one slip is issued per WAIT period.
- The block that completes `LOCK_CNT` is not forwarded. The next block is forwarded.
- The block that drops lock is still forwarded (lock was 1 when it arrived).
- Blocks arriving in WAIT are neither evaluated nor forwarded.
- Reset mid-operation forces HUNT immediately. Any in-progress slip pulse is cancelled.
- Gaps in `S_VALID` do not advance block counters. The BER timer counts cycles regardless of `S_VALID`.

## Structure

- Shared package `p66b_pkg`:
  - header constants `P66_HDR_DATA`=2'b01 and `P66_HDR_CTRL`=2'b10;
  - the FSM state encoding (HUNT, WAIT, LOCKED);
  - default parameter constants.
- Sub-module `p66b_ber_mon` (timer, `ber_cnt`, `o_hi_ber`). Its inputs are `i_clk`, `i_reset`, an enable (`o_block_lock`) and an invalid-header strobe.
- Top level holds the FSM and the forwarding register.

## Test plan

- Clean stream: 70 blocks with header 2'b01.
  - `o_block_lock` rises one cycle after block 64.
  - `M_VALID` first asserts for block 65.
  - `o_slip` stays 0 throughout.
- Misaligned start: block 3 has header 2'b11.
  - `o_slip` pulses once, one cycle after it.
  - Blocks 4–7 are ignored.
  - Lock after 64 further valid blocks (blocks 8–71).
- Loss of lock: after lock, inject 16 invalid headers within one 64-block window.
  - `o_block_lock` falls and `o_slip` pulses after the 16th.
  - Inject 15 invalid headers in a later window instead: lock is held.
- Boundary: the 16th invalid header lands on the 64th block of a window.
  - Lock is lost; the window reset does not rescue it.
- hi-BER, with `BER_TIMER`=100 in sim and lock held:
  - 16 invalid headers within 100 cycles (kept under 16 per 64-block window) → `o_hi_ber`=1.
  - A following window with 0 errors → `o_hi_ber`=0 at its wrap.
- Reset asserted while in LOCKED, asynchronously mid-cycle:
  - All outputs go to 0 immediately.
  - After release, 64 valid blocks are required to relock.

Source files
------------

// File: rtl/p66b_pkg.sv
// Shared definitions for the 64b/66b block-lock path: sync header codes,
// lock FSM encoding and default tuning constants.
package p66b_pkg;

  localparam logic [1:0] P66_HDR_DATA = 2'b01;
  localparam logic [1:0] P66_HDR_CTRL = 2'b10;

  typedef enum logic [1:0] {
    StHunt   = 2'd0,
    StWait   = 2'd1,
    StLocked = 2'd2
  } lock_state_e;

  localparam int unsigned DEF_LOCK_CNT  = 64;
  localparam int unsigned DEF_WIN_CNT   = 64;
  localparam int unsigned DEF_BAD_LIMIT = 16;
  localparam int unsigned DEF_SLIP_WAIT = 4;
  localparam int unsigned DEF_BER_TIMER = 19531;
  localparam int unsigned DEF_BER_LIMIT = 16;

  // A sync header is valid only when its two bits differ.
  function automatic logic hdr_valid(input logic [1:0] hdr);
    return (hdr == P66_HDR_DATA) || (hdr == P66_HDR_CTRL);
  endfunction

endpackage

// File: rtl/p66b_ber_mon.sv
// High bit-error-rate monitor: counts invalid headers over a fixed window of
// clock cycles while block lock is held.
module p66b_ber_mon
  import p66b_pkg::*;
#(
  parameter int unsigned BER_TIMER = DEF_BER_TIMER,
  parameter int unsigned BER_LIMIT = DEF_BER_LIMIT
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic en,
  input  logic bad_hdr,
  output logic o_hi_ber
);

  localparam int unsigned TW = $clog2(BER_TIMER + 1);
  localparam int unsigned CW = $clog2(BER_LIMIT + 1);

  logic [TW-1:0] timer;
  logic [CW-1:0] ber_cnt;
  logic [CW-1:0] ber_inc;
  logic          wrap;

  // Saturating error count including this cycle's header, and window end.
  always_comb begin
    wrap    = (timer == TW'(BER_TIMER - 1));
    ber_inc = ber_cnt;
    if (bad_hdr && (ber_cnt != CW'(BER_LIMIT))) begin
      ber_inc = ber_cnt + 1'b1;
    end
  end

  // Window timer and hi-BER flag; everything held at zero without lock.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      timer    <= '0;
      ber_cnt  <= '0;
      o_hi_ber <= 1'b0;
    end else if (!en) begin
      timer    <= '0;
      ber_cnt  <= '0;
      o_hi_ber <= 1'b0;
    end else if (wrap) begin
      // An error on the wrap cycle still belongs to the expiring window.
      timer    <= '0;
      ber_cnt  <= '0;
      o_hi_ber <= (ber_inc == CW'(BER_LIMIT));
    end else begin
      timer   <= timer + 1'b1;
      ber_cnt <= ber_inc;
      if (ber_inc == CW'(BER_LIMIT)) begin
        o_hi_ber <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/p66b_lock_ctrl.sv
// 64b/66b block-lock controller: hunts for header alignment, commands gearbox
// slips, tracks loss of lock and forwards blocks only while locked.
module p66b_lock_ctrl
  import p66b_pkg::*;
#(
  parameter int unsigned LOCK_CNT  = DEF_LOCK_CNT,
  parameter int unsigned WIN_CNT   = DEF_WIN_CNT,
  parameter int unsigned BAD_LIMIT = DEF_BAD_LIMIT,
  parameter int unsigned SLIP_WAIT = DEF_SLIP_WAIT,
  parameter int unsigned BER_TIMER = DEF_BER_TIMER,
  parameter int unsigned BER_LIMIT = DEF_BER_LIMIT
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        S_VALID,
  input  logic [65:0] S_DATA,
  output logic        o_slip,
  output logic        o_block_lock,
  output logic        o_hi_ber,
  output logic        M_VALID,
  output logic [65:0] M_DATA
);

  localparam int unsigned GW = $clog2(LOCK_CNT + 1);
  localparam int unsigned WW = $clog2(WIN_CNT + 1);
  localparam int unsigned BW = $clog2(BAD_LIMIT + 1);
  localparam int unsigned SW = $clog2(SLIP_WAIT + 1);

  lock_state_e   state;
  logic [GW-1:0] good_cnt;
  logic [WW-1:0] win_cnt;
  logic [BW-1:0] bad_cnt;
  logic [SW-1:0] wait_cnt;

  logic          hdr_ok;
  logic          bad_evt;
  logic [WW-1:0] win_inc;
  logic [BW-1:0] bad_inc;

  // Header classification and the locked-window counts including this block.
  always_comb begin
    hdr_ok  = hdr_valid(S_DATA[1:0]);
    bad_evt = S_VALID && !hdr_ok;
    win_inc = win_cnt + 1'b1;
    bad_inc = bad_cnt + BW'(bad_evt);
  end

  // Lock FSM with registered slip and lock outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= StHunt;
      good_cnt     <= '0;
      win_cnt      <= '0;
      bad_cnt      <= '0;
      wait_cnt     <= '0;
      o_slip       <= 1'b0;
      o_block_lock <= 1'b0;
    end else begin
      o_slip <= 1'b0;
      if (S_VALID) begin
        unique case (state)
          StHunt: begin
            if (!hdr_ok) begin
              o_slip   <= 1'b1;
              good_cnt <= '0;
              wait_cnt <= '0;
              state    <= StWait;
            end else if (good_cnt == GW'(LOCK_CNT - 1)) begin
              good_cnt     <= '0;
              win_cnt      <= '0;
              bad_cnt      <= '0;
              o_block_lock <= 1'b1;
              state        <= StLocked;
            end else begin
              good_cnt <= good_cnt + 1'b1;
            end
          end
          StLocked: begin
            // Loss of lock takes priority over a window rollover.
            if (bad_inc == BW'(BAD_LIMIT)) begin
              win_cnt      <= '0;
              bad_cnt      <= '0;
              wait_cnt     <= '0;
              o_block_lock <= 1'b0;
              o_slip       <= 1'b1;
              state        <= StWait;
            end else if (win_inc == WW'(WIN_CNT)) begin
              win_cnt <= '0;
              bad_cnt <= '0;
            end else begin
              win_cnt <= win_inc;
              bad_cnt <= bad_inc;
            end
          end
          StWait: begin
            // Gearbox is realigning; these blocks are not evaluated.
            if (wait_cnt == SW'(SLIP_WAIT - 1)) begin
              wait_cnt <= '0;
              good_cnt <= '0;
              state    <= StHunt;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          default: state <= StHunt;
        endcase
      end
    end
  end

  // Forwarding register; gated by the lock value seen before this block.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      M_VALID <= 1'b0;
      M_DATA  <= '0;
    end else begin
      M_VALID <= S_VALID && o_block_lock;
      if (S_VALID) begin
        M_DATA <= S_DATA;
      end
    end
  end

  p66b_ber_mon #(
    .BER_TIMER(BER_TIMER),
    .BER_LIMIT(BER_LIMIT)
  ) u_ber_mon (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .en      (o_block_lock),
    .bad_hdr (bad_evt),
    .o_hi_ber(o_hi_ber)
  );

endmodule

// File: tb/tb_p66b_lock_ctrl.sv
// Bench for p66b_lock_ctrl: behavioural model feeds an expectation queue on
// every driven cycle; entries are popped and compared after the clock edge.
module tb_p66b_lock_ctrl;

  localparam int LOCK = 64;
  localparam int WIN  = 64;
  localparam int BADL = 16;
  localparam int SWT  = 4;
  localparam int BT   = 100;
  localparam int BL   = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        sv;
  logic [65:0] sd;
  logic        o_slip, o_block_lock, o_hi_ber, m_valid;
  logic [65:0] m_data;

  always #5 clk = ~clk;

  p66b_lock_ctrl #(
    .LOCK_CNT (LOCK),
    .WIN_CNT  (WIN),
    .BAD_LIMIT(BADL),
    .SLIP_WAIT(SWT),
    .BER_TIMER(BT),
    .BER_LIMIT(BL)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .S_VALID     (sv),
    .S_DATA      (sd),
    .o_slip      (o_slip),
    .o_block_lock(o_block_lock),
    .o_hi_ber    (o_hi_ber),
    .M_VALID     (m_valid),
    .M_DATA      (m_data)
  );

  typedef struct packed {
    logic        slip;
    logic        lock;
    logic        hi;
    logic        mv;
    logic [65:0] md;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model state (0 hunt, 1 wait, 2 locked).
  int          m_state, m_good, m_win, m_bad, m_wait, m_timer, m_ber;
  logic        m_lock, m_slip, m_hi, m_mv;
  logic [65:0] m_md;

  exp_t last;
  logic prev_slip;
  int   slip_total;

  task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_good = 0; m_win = 0; m_bad = 0; m_wait = 0;
    m_timer = 0; m_ber = 0;
    m_lock = 0; m_slip = 0; m_hi = 0; m_mv = 0; m_md = '0;
    prev_slip = 0; slip_total = 0;
  endtask

  task automatic model_step(input logic v, input logic [65:0] d);
    logic bad;
    int   be;
    bad = v && !((d[1:0] == 2'b01) || (d[1:0] == 2'b10));
    // hi-BER monitor sees the lock value from before this edge
    if (!m_lock) begin
      m_timer = 0; m_ber = 0; m_hi = 0;
    end else begin
      be = m_ber + int'(bad);
      if (be > BL) be = BL;
      if (be == BL) m_hi = 1;
      if (m_timer == BT - 1) begin
        if (be < BL) m_hi = 0;
        m_ber = 0; m_timer = 0;
      end else begin
        m_ber = be; m_timer++;
      end
    end
    m_mv = v && m_lock;
    if (v) m_md = d;
    m_slip = 0;
    if (v) begin
      case (m_state)
        0: begin
          if (bad) begin
            m_slip = 1; m_good = 0; m_wait = 0; m_state = 1;
          end else begin
            m_good++;
            if (m_good == LOCK) begin
              m_state = 2; m_lock = 1; m_good = 0; m_win = 0; m_bad = 0;
            end
          end
        end
        2: begin
          m_win++;
          m_bad += int'(bad);
          if (m_bad == BADL) begin
            m_lock = 0; m_slip = 1; m_state = 1; m_wait = 0;
          end else if (m_win == WIN) begin
            m_win = 0; m_bad = 0;
          end
        end
        default: begin
          m_wait++;
          if (m_wait == SWT) begin
            m_state = 0; m_good = 0;
          end
        end
      endcase
    end
  endtask

  // One clock: drive at negedge, push expectation, pop and compare after edge.
  task automatic step(input logic v, input logic [1:0] hdr);
    logic [65:0] d;
    exp_t        e;
    exp_t        g;
    @(negedge clk);
    d  = {$urandom, $urandom, hdr};
    sv = v;
    sd = d;
    model_step(v, d);
    sb.push_back({m_slip, m_lock, m_hi, m_mv, m_md});
    @(posedge clk);
    #1;
    g = {o_slip, o_block_lock, o_hi_ber, m_valid, m_data};
    e = sb.pop_front();
    chk("slip", 66'(g.slip), 66'(e.slip));
    chk("block_lock", 66'(g.lock), 66'(e.lock));
    chk("hi_ber", 66'(g.hi), 66'(e.hi));
    chk("m_valid", 66'(g.mv), 66'(e.mv));
    chk("m_data", g.md, e.md);
    chk("slip_b2b", 66'(g.slip & prev_slip), 66'(0));
    prev_slip = g.slip;
    slip_total += int'(g.slip);
    last = g;
  endtask

  task automatic sync_reset();
    @(negedge clk);
    rst = 1'b1;
    sv  = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic relock();
    for (int i = 0; i < SWT; i++) step(1'b1, 2'b11);
    for (int i = 0; i < LOCK; i++) step(1'b1, 2'b10);
    chk("relock", 66'(last.lock), 66'(1));
  endtask

  initial begin
    rst = 1'b1;
    sv  = 1'b0;
    sd  = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_slip", 66'(o_slip), 66'(0));
    chk("rst_lock", 66'(o_block_lock), 66'(0));
    chk("rst_hi_ber", 66'(o_hi_ber), 66'(0));
    chk("rst_m_valid", 66'(m_valid), 66'(0));
    chk("rst_m_data", m_data, 66'(0));
    rst = 1'b0;

    // Clean stream with one idle gap that must not advance the count.
    for (int i = 1; i <= 70; i++) begin
      step(1'b1, 2'b01);
      if (i == 10) step(1'b0, 2'b01);
      if (i == 63) chk("clean_lock_63", 66'(last.lock), 66'(0));
      if (i == 64) begin
        chk("clean_lock_64", 66'(last.lock), 66'(1));
        chk("clean_mv_64", 66'(last.mv), 66'(0));
      end
      if (i == 65) chk("clean_mv_65", 66'(last.mv), 66'(1));
    end
    chk("clean_no_slip", 66'(slip_total), 66'(0));

    // Misaligned start; blocks 4-7 invalid but ignored during the wait.
    sync_reset();
    for (int i = 1; i <= 71; i++) begin
      step(1'b1, (i == 3) ? 2'b11 : ((i >= 4 && i <= 7) ? 2'b00 : 2'b01));
      if (i == 3) chk("mis_slip_3", 66'(last.slip), 66'(1));
      if (i == 4) chk("mis_slip_4", 66'(last.slip), 66'(0));
      if (i == 70) chk("mis_lock_70", 66'(last.lock), 66'(0));
      if (i == 71) chk("mis_lock_71", 66'(last.lock), 66'(1));
    end
    chk("mis_one_slip", 66'(slip_total), 66'(1));

    // 15 errors in a window hold lock; 16 in the next drop it.
    for (int j = 0; j < WIN; j++) step(1'b1, (j < 15) ? 2'b00 : 2'b10);
    chk("win15_hold", 66'(last.lock), 66'(1));
    for (int j = 0; j < 16; j++) begin
      step(1'b1, 2'b11);
      if (j == 14) chk("win16_lock_15", 66'(last.lock), 66'(1));
    end
    chk("win16_lock", 66'(last.lock), 66'(0));
    chk("win16_slip", 66'(last.slip), 66'(1));
    relock();

    // 16th error on the last block of a window still drops lock.
    for (int j = 0; j < WIN; j++) begin
      step(1'b1, (j < 15 || j == WIN - 1) ? 2'b11 : 2'b01);
      if (j == WIN - 2) chk("bnd_lock_63", 66'(last.lock), 66'(1));
    end
    chk("bnd_lock_64", 66'(last.lock), 66'(0));
    chk("bnd_slip", 66'(last.slip), 66'(1));
    chk("bnd_fwd", 66'(last.mv), 66'(1));
    relock();

    // hi-BER: 8 errors at the end of one window, 8 at the start of the next.
    for (int k = 1; k <= 210; k++) begin
      step(1'b1, (k >= 57 && k <= 72) ? 2'b00 : 2'b01);
      if (k == 71) chk("ber_hi_15", 66'(last.hi), 66'(0));
      if (k == 72) chk("ber_hi_16", 66'(last.hi), 66'(1));
      if (k == 100) chk("ber_hi_wrap1", 66'(last.hi), 66'(1));
      if (k == 199) chk("ber_hi_199", 66'(last.hi), 66'(1));
      if (k == 200) chk("ber_hi_wrap2", 66'(last.hi), 66'(0));
    end
    chk("ber_lock_held", 66'(last.lock), 66'(1));

    // Asynchronous reset mid-cycle while locked and forwarding.
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_slip", 66'(o_slip), 66'(0));
    chk("arst_lock", 66'(o_block_lock), 66'(0));
    chk("arst_hi_ber", 66'(o_hi_ber), 66'(0));
    chk("arst_m_valid", 66'(m_valid), 66'(0));
    chk("arst_m_data", m_data, 66'(0));
    sv = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= LOCK; i++) begin
      step(1'b1, 2'b10);
      if (i == LOCK - 1) chk("arst_lock_63", 66'(last.lock), 66'(0));
    end
    chk("arst_lock_64", 66'(last.lock), 66'(1));

    chk("sb_empty", 66'(sb.size()), 66'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
